// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controller: state encoding,
// one-hot lamp patterns {red, yellow, green} and delay-timer selection.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_INIT        = 3'd0,
    S_HWY_GREEN   = 3'd1,
    S_HWY_YELLOW  = 3'd2,
    S_ALLRED_A    = 3'd3,
    S_FARM_GREEN  = 3'd4,
    S_FARM_YELLOW = 3'd5,
    S_ALLRED_B    = 3'd6,
    S_FLASH       = 3'd7
  } state_t;

  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] DARK = 3'b000;

  localparam logic [1:0] TSEL_NONE  = 2'd0;
  localparam logic [1:0] TSEL_LONG  = 2'd1;
  localparam logic [1:0] TSEL_SHORT = 2'd2;

  // Delay requested on entry to a state.
  function automatic logic [1:0] timer_sel(input state_t s);
    case (s)
      S_HWY_GREEN, S_FARM_GREEN:                           timer_sel = TSEL_LONG;
      S_HWY_YELLOW, S_ALLRED_A, S_FARM_YELLOW, S_ALLRED_B: timer_sel = TSEL_SHORT;
      default:                                             timer_sel = TSEL_NONE;
    endcase
  endfunction

  // Returns {hwy_light, farm_light} for the non-fault states.
  function automatic logic [5:0] lights_for(input state_t s);
    case (s)
      S_HWY_GREEN:   lights_for = {GRN, RED};
      S_HWY_YELLOW:  lights_for = {YEL, RED};
      S_FARM_GREEN:  lights_for = {RED, GRN};
      S_FARM_YELLOW: lights_for = {RED, YEL};
      default:       lights_for = {RED, RED};
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_sequencer.sv
// Highway / farm-road intersection master: sequences both heads through the
// shared delay timer and latches a flashing-red fault if the timer goes silent.
module traffic_light_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned WD_CYCLES  = 300,
  parameter int unsigned FLASH_HALF = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       farm_car,
  input  logic       timer_done,
  output logic       start_long,
  output logic       start_short,
  output logic [2:0] hwy_light,
  output logic [2:0] farm_light,
  output logic       fault,
  output logic [2:0] state_dbg
);

  localparam int unsigned WDW = $clog2(WD_CYCLES + 1);
  localparam int unsigned FLW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(WD_CYCLES - 1);
  localparam logic [FLW-1:0] FL_LAST = FLW'(FLASH_HALF - 1);

  state_t         state, state_next;
  logic           car_req, min_green_met, timer_pending;
  logic [WDW-1:0] wd_cnt;
  logic [FLW-1:0] flash_cnt;
  logic           done_ok, wd_expire, entering;
  logic [1:0]     sel;

  assign state_dbg = state;

  always_comb begin
    done_ok    = timer_done && timer_pending;
    wd_expire  = timer_pending && !timer_done && (wd_cnt == WD_LAST);
    state_next = state;
    case (state)
      S_INIT:        state_next = S_HWY_GREEN;
      // farm_car is looked at directly so a car arriving after the minimum
      // green turns the light on the very edge that samples it.
      S_HWY_GREEN:   if ((min_green_met || done_ok) && (car_req || farm_car))
                       state_next = S_HWY_YELLOW;
      S_HWY_YELLOW:  if (done_ok) state_next = S_ALLRED_A;
      S_ALLRED_A:    if (done_ok) state_next = S_FARM_GREEN;
      S_FARM_GREEN:  if (done_ok) state_next = S_FARM_YELLOW;
      S_FARM_YELLOW: if (done_ok) state_next = S_ALLRED_B;
      S_ALLRED_B:    if (done_ok) state_next = S_HWY_GREEN;
      S_FLASH:       state_next = S_FLASH;
    endcase
    if (state != S_FLASH && wd_expire) state_next = S_FLASH;
    entering = (state_next != state);
    sel      = timer_sel(state_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_INIT;
      hwy_light     <= RED;
      farm_light    <= RED;
      start_long    <= 1'b0;
      start_short   <= 1'b0;
      fault         <= 1'b0;
      car_req       <= 1'b0;
      min_green_met <= 1'b0;
      timer_pending <= 1'b0;
      wd_cnt        <= '0;
      flash_cnt     <= '0;
    end else begin
      state       <= state_next;
      start_long  <= 1'b0;
      start_short <= 1'b0;
      if (state_next == S_FLASH) begin
        fault         <= 1'b1;
        timer_pending <= 1'b0;
        wd_cnt        <= '0;
        if (state != S_FLASH) begin
          hwy_light  <= RED;
          farm_light <= RED;
          flash_cnt  <= '0;
        end else if (flash_cnt == FL_LAST) begin
          flash_cnt  <= '0;
          hwy_light  <= (hwy_light == RED) ? DARK : RED;
          farm_light <= (hwy_light == RED) ? DARK : RED;
        end else begin
          flash_cnt <= flash_cnt + FLW'(1);
        end
      end else begin
        {hwy_light, farm_light} <= lights_for(state_next);
        if (entering && sel != TSEL_NONE) begin
          start_long    <= (sel == TSEL_LONG);
          start_short   <= (sel == TSEL_SHORT);
          timer_pending <= 1'b1;
          wd_cnt        <= '0;
        end else if (done_ok) begin
          timer_pending <= 1'b0;
        end else if (timer_pending && wd_cnt != WDW'(WD_CYCLES)) begin
          wd_cnt <= wd_cnt + WDW'(1);
        end
        // The entry edge into FARM_GREEN wins over a same-cycle farm_car.
        if (state_next == S_FARM_GREEN && state != S_FARM_GREEN)
          car_req <= 1'b0;
        else if (farm_car && state != S_FARM_GREEN)
          car_req <= 1'b1;
        if (state_next == S_HWY_GREEN && state != S_HWY_GREEN)
          min_green_met <= 1'b0;
        else if (state == S_HWY_GREEN && done_ok)
          min_green_met <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Scoreboard bench for traffic_light_sequencer: a behavioural model predicts
// every cycle's outputs, and a small timer emulator supplies done pulses.
module tb_traffic_light_sequencer;

  localparam int WD        = 40;
  localparam int FH        = 5;
  localparam int LONG_CYC  = 20;
  localparam int SHORT_CYC = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       farm_car = 1'b0;
  logic       timer_done = 1'b0;
  logic       start_long, start_short, fault;
  logic [2:0] hwy_light, farm_light, state_dbg;

  always #5 clk = ~clk;

  traffic_light_sequencer #(.WD_CYCLES(WD), .FLASH_HALF(FH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .farm_car    (farm_car),
    .timer_done  (timer_done),
    .start_long  (start_long),
    .start_short (start_short),
    .hwy_light   (hwy_light),
    .farm_light  (farm_light),
    .fault       (fault),
    .state_dbg   (state_dbg)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [15:0] exp_q[$];

  int       m_state, m_wd, m_fcnt;
  bit       m_req, m_ming, m_pend, m_fault, m_sl, m_ss;
  logic [2:0] m_hl, m_fl;
  int       t_cnt;
  bit       timer_en;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {4'h0, state_dbg, hwy_light, farm_light, start_long, start_short, fault};
  endfunction

  function automatic logic [15:0] model_vec();
    return {4'h0, 3'(m_state), m_hl, m_fl, m_sl, m_ss, m_fault};
  endfunction

  task automatic model_reset();
    m_state = 0; m_wd = 0; m_fcnt = 0;
    m_req = 0; m_ming = 0; m_pend = 0; m_fault = 0; m_sl = 0; m_ss = 0;
    m_hl = 3'b100; m_fl = 3'b100;
  endtask

  // States: 0 INIT, 1 HG, 2 HY, 3 AR_A, 4 FG, 5 FY, 6 AR_B, 7 FLASH.
  task automatic model_step(input bit fc, input bit td);
    int ns;
    bit dok;
    dok  = td && m_pend;
    m_sl = 0;
    m_ss = 0;
    if (m_state == 7) begin
      m_fcnt++;
      if (m_fcnt == FH) begin
        m_fcnt = 0;
        m_hl = (m_hl == 3'b100) ? 3'b000 : 3'b100;
        m_fl = m_hl;
      end
      return;
    end
    ns = m_state;
    case (m_state)
      0: ns = 1;
      1: if ((m_ming || dok) && (m_req || fc)) ns = 2;
      2, 3, 4, 5: if (dok) ns = m_state + 1;
      6: if (dok) ns = 1;
      default: ns = m_state;
    endcase
    if (m_pend && !td && m_wd == WD - 1) ns = 7;
    if (ns == 4 && m_state != 4) m_req = 0;
    else if (fc && m_state != 4) m_req = 1;
    if (ns == 1 && m_state != 1) m_ming = 0;
    else if (m_state == 1 && dok) m_ming = 1;
    if (ns == 7) begin
      m_fault = 1; m_pend = 0; m_wd = 0; m_fcnt = 0;
      m_hl = 3'b100; m_fl = 3'b100;
    end else begin
      if (ns != m_state) begin
        if (ns == 1 || ns == 4) m_sl = 1; else m_ss = 1;
        m_pend = 1;
        m_wd = 0;
      end else if (dok) m_pend = 0;
      else if (m_pend) m_wd++;
      case (ns)
        1:       begin m_hl = 3'b001; m_fl = 3'b100; end
        2:       begin m_hl = 3'b010; m_fl = 3'b100; end
        4:       begin m_hl = 3'b100; m_fl = 3'b001; end
        5:       begin m_hl = 3'b100; m_fl = 3'b010; end
        default: begin m_hl = 3'b100; m_fl = 3'b100; end
      endcase
    end
    m_state = ns;
  endtask

  // Called at a negedge: drive, predict, then compare on the following negedge.
  task automatic tick(input bit fc, input bit td);
    logic [15:0] e;
    farm_car   = fc;
    timer_done = td;
    model_step(fc, td);
    exp_q.push_back(model_vec());
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) check_val("queue_empty", 16'd1, 16'd0);
    else begin
      e = exp_q.pop_front();
      check_val("cycle", dut_vec(), e);
    end
  endtask

  task automatic cycle(input bit fc);
    bit td;
    td = 0;
    if (t_cnt > 0) begin
      t_cnt--;
      td = (t_cnt == 0) && timer_en;
    end
    tick(fc, td);
    if (m_sl) t_cnt = LONG_CYC;
    else if (m_ss) t_cnt = SHORT_CYC;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous response, releases at a negedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_val("rst_async", dut_vec(), {4'h0, 3'd0, 3'b100, 3'b100, 3'b000});
    model_reset();
    t_cnt = 0;
    timer_en = 1;
    farm_car = 1'b0;
    timer_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    model_reset();
    t_cnt = 0;
    timer_en = 1;
    @(negedge clk);
    do_reset();

    // No traffic: INIT -> HG with start_long, then hold green after done.
    repeat (40) cycle(0);
    check_val("hold_green", 16'(state_dbg), 16'd1);

    // Stray done while waiting for a car.
    tick(0, 1);
    repeat (3) tick(0, 0);

    // Car after minimum green: yellow on the sampling edge, full cycle back.
    cycle(1);
    check_val("car_late_yel", 16'(state_dbg), 16'd2);
    n = 0;
    do begin cycle(0); n++; end while (!(m_state == 1 && m_sl) && n < 150);
    check_val("back_hwy_1", 16'(state_dbg), 16'd1);

    // One-cycle car pulse before done.
    cycle(0);
    cycle(0);
    cycle(1);
    n = 0;
    do begin cycle(0); n++; end while (!(m_state == 1 && m_sl) && n < 150);
    check_val("back_hwy_2", 16'(state_dbg), 16'd1);

    // Car on the same cycle as done, nothing latched yet.
    n = 0;
    while (t_cnt != 1 && n < 50) begin cycle(0); n++; end
    cycle(1);
    check_val("same_edge_yel", 16'(state_dbg), 16'd2);

    // Withhold done in ALLRED_A: fault exactly WD cycles after the pulse.
    n = 0;
    while (!(m_state == 3 && m_ss) && n < 50) begin cycle(0); n++; end
    timer_en = 0;
    n = 0;
    while (fault !== 1'b1 && n < WD + 20) begin cycle(0); n++; end
    check_val("wd_latency", 16'(n), 16'(WD));
    repeat (7) cycle(0);
    tick(1, 1);
    repeat (15) cycle(0);
    check_val("fault_sticky", 16'(fault), 16'd1);
    check_val("flash_state", 16'(state_dbg), 16'd7);

    // Reset in the middle of FARM_GREEN, then the normal start-up again.
    do_reset();
    cycle(1);
    n = 0;
    while (m_state != 4 && n < 100) begin cycle(0); n++; end
    repeat (5) cycle(0);
    check_val("in_farm_green", 16'(state_dbg), 16'd4);
    do_reset();
    repeat (30) cycle(0);
    check_val("restart_green", 16'(state_dbg), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_sequencer.md
# traffic_light_sequencer

- Master controller for a highway / farm-road intersection.
- Sequences both light heads through green, yellow and all-red phases by triggering the shared delay timer (long = 25 s, short = 4 s) and waiting for its done pulse.
- Holds the highway green until a farm-road vehicle is latched.
- A timer watchdog forces a latched flashing-red fault mode.
- Sits between the timer instance and the lamp drivers at intersection top level.

## Interface

Parameters:
- WD_CYCLES, 300: max cycles to wait for timer_done after any start pulse; must exceed the 25 s count at the system clock.
- FLASH_HALF, 5: cycles per half-period of fault-mode red flashing.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- farm_car  in  1  farm-road vehicle sensor, level, already synchronous to clk.
- timer_done  in  1  one-cycle pulse from the delay timer.
- start_long  out  1  one-cycle pulse; starts a 25 s delay.
- start_short  out  1  one-cycle pulse; starts a 4 s delay.
- hwy_light  out  3  one-hot {red, yellow, green} for the highway head.
- farm_light  out  3  one-hot {red, yellow, green} for the farm-road head.
- fault  out  1  sticky watchdog fault.
- state_dbg  out  3  current state encoding.

## Operation

States, each listed with the start pulse it issues on entry:
- INIT: none.
- HWY_GREEN: long.
- HWY_YELLOW: short.
- ALLRED_A: short.
- FARM_GREEN: long.
- FARM_YELLOW: short.
- ALLRED_B: short.
- FLASH: none.

Transitions:
- INIT -> HWY_GREEN unconditionally on the first clock edge after reset release.
- HWY_GREEN:
  - On timer_done, set min_green_met.
  - When min_green_met and car_req are both 1, go to HWY_YELLOW.
  - car_req may arrive before or after done.
- HWY_YELLOW -> ALLRED_A -> FARM_GREEN -> FARM_YELLOW -> ALLRED_B -> HWY_GREEN, each on timer_done.

Vehicle request and flags:
- car_req is a sticky latch: set by farm_car=1 in any state except FARM_GREEN.
- car_req is cleared on the edge entering FARM_GREEN.
- farm_car high on the same cycle as the entry edge is ignored. The vehicle is being served.
- min_green_met is cleared on entry to HWY_GREEN.

Start pulses and done handling:
- Start pulses are registered and asserted in the first cycle of the new state only; never both at once.
- timer_pending is set with each start pulse and cleared by timer_done.
- timer_done while not pending is ignored. Example: a stray pulse while HWY_GREEN waits for a car.

Watchdog and fault mode:
- wd_cnt counts only while timer_pending is 1 and is cleared by every start pulse.
- When wd_cnt reaches WD_CYCLES-1 without done, go to FLASH and set fault=1.
- In FLASH:
  - Both heads toggle red/dark every FLASH_HALF cycles, starting at red.
  - Yellow and green are off.
  - Start pulses are 0.
  - timer_done and farm_car are ignored.
  - Exit is by reset only.

Light decoding, registered:
- HWY_GREEN: hwy=G, farm=R.
- HWY_YELLOW: hwy=Y, farm=R.
- FARM_GREEN: hwy=R, farm=G.
- FARM_YELLOW: hwy=R, farm=Y.
- INIT, ALLRED_A, ALLRED_B: both R.
- Outside FLASH, both heads are never non-red in the same cycle.

## Timing

Reset values:
- state=INIT, hwy_light=farm_light=3'b100.
- start_long=start_short=0, fault=0.
- car_req=min_green_met=timer_pending=0, wd_cnt=0, state_dbg=0.
- Reset mid-phase returns to these values immediately, asynchronously. Timer re-arm depends on the timer's own reset.

Cycle-level behaviour:
- Lights, state_dbg and start pulses update on the same edge as the state. No combinational input-to-output paths.
- Phase advance latency: timer_done sampled high at edge N gives the new state, lights and start pulse at N. The timer sees the start at N+1.
- A car latched after min_green_met gives the HWY_YELLOW transition on the edge sampling farm_car=1.
- Watchdog in HWY_GREEN after done: not pending, so an indefinite wait for a car never faults.
- wd_cnt width is $clog2(WD_CYCLES+1). The flash counter width is $clog2(FLASH_HALF). Both saturate/wrap only at their terminal counts.

## Structure

- Shared package `traffic_pkg`:
  - state enum;
  - light one-hot constants RED/YEL/GRN/DARK;
  - timer select constants.
- Single module. No sub-module; watchdog and flash counters are small inline counters.
- The timer is instantiated beside this block at top level, not inside it.

## Test plan

- Reset release, farm_car=0, done pulses supplied:
  - INIT -> HWY_GREEN with start_long in cycle 1;
  - hwy=G, farm=R indefinitely after done;
  - no further start pulses.
- farm_car pulse 1 cycle during HWY_GREEN, before done:
  - on done -> HWY_YELLOW with start_short;
  - full cycle Y -> all-red -> farm G (start_long) -> farm Y -> all-red -> HWY_GREEN.
- farm_car high on the same cycle as timer_done in HWY_GREEN (req not yet latched) -> HWY_YELLOW on that edge.
- Withhold timer_done after start_short in ALLRED_A:
  - fault=1 and FLASH exactly WD_CYCLES cycles after the pulse;
  - red toggles every 5 cycles;
  - later done is ignored.
- Stray timer_done in HWY_GREEN while waiting for a car -> no state change, no start pulse.
- rst_n low mid-FARM_GREEN -> all outputs at reset values immediately; restart sequence identical to scenario 1.
